// File: rtl/page_walker_pkg.sv
// Shared definitions for the page walker.
// Holds the walker state encoding, the PTE valid-bit position and the default
// values of the OFFSET / PHYS_ADDR_SIZE / TIMEOUT parameters.
package page_walker_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_REQ   = 3'd1,
        ST_FILL  = 3'd2,
        ST_RESP  = 3'd3,
        ST_FAULT = 3'd4
    } pw_state_t;

    localparam int PTE_VALID_BIT          = 0;
    localparam int DEFAULT_OFFSET         = 12;
    localparam int DEFAULT_PHYS_ADDR_SIZE = 24;
    localparam int DEFAULT_TIMEOUT        = 255;

endpackage

// File: rtl/pw_rr_arbiter.sv
// Two-way round-robin arbiter for the page walker (I-side vs D-side).
// Ports:
//   clock, reset  - clock, synchronous active-high reset
//   en            - arbitration allowed this cycle (walker idle)
//   i_req, d_req  - pending misses from the I and D TLBs
//   grant_valid   - a requester is granted this cycle
//   grant_d       - 1 = D-side granted, 0 = I-side granted
// When both request, the side that was not granted last wins; the pointer
// moves only when a grant is actually issued. After reset the I-side wins.
module pw_rr_arbiter (
    input  logic clock,
    input  logic reset,
    input  logic en,
    input  logic i_req,
    input  logic d_req,
    output logic grant_valid,
    output logic grant_d
);

    // 1 = D-side has priority on the next contested grant
    logic prio_d_reg;

    always_comb begin
        grant_valid = en & (i_req | d_req);
        grant_d     = d_req & (~i_req | prio_d_reg);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            prio_d_reg <= 1'b0;
        end else if (grant_valid) begin
            prio_d_reg <= ~grant_d;
        end
    end

endmodule

// File: rtl/page_walker.sv
// Single-level hardware page-table walker shared by an I-TLB and a D-TLB.
// A granted miss reads one PTE at ptbr + vpage*4; a valid PTE (bit 0 set) is
// written into the requesting TLB and acknowledged with done, otherwise the
// requester receives a fault pulse.
// Ports:
//   clock, reset                      - clock, synchronous active-high reset
//   i_miss_i/i_vpage_i, d_miss_i/...  - TLB miss requests (level, held)
//   i_done_o/i_fault_o, d_done_o/...  - one-cycle completion pulses
//   ptbr_i                            - page-table base byte address
//   mem_req_o/mem_addr_o              - PTE read request, held until ack
//   mem_ack_i/mem_rdata_i             - one-cycle ack with PTE data
//   i_we_o/d_we_o, w_virtual_page_o,
//   w_phys_page_o                     - TLB fill interface
//   busy_o                            - walker not idle
// Build option: define PAGE_WALKER_TIMEOUT_EN to abort a walk as a fault after
// TIMEOUT request cycles without an ack; otherwise the walker waits forever.
module page_walker
    import page_walker_pkg::*;
#(
    parameter int OFFSET         = DEFAULT_OFFSET,
    parameter int PHYS_ADDR_SIZE = DEFAULT_PHYS_ADDR_SIZE,
    parameter int TIMEOUT        = DEFAULT_TIMEOUT
) (
    input  logic                               clock,
    input  logic                               reset,
    input  logic                               i_miss_i,
    input  logic [31-OFFSET:0]                 i_vpage_i,
    output logic                               i_done_o,
    output logic                               i_fault_o,
    input  logic                               d_miss_i,
    input  logic [31-OFFSET:0]                 d_vpage_i,
    output logic                               d_done_o,
    output logic                               d_fault_o,
    input  logic [31:0]                        ptbr_i,
    output logic                               mem_req_o,
    output logic [31:0]                        mem_addr_o,
    input  logic                               mem_ack_i,
    input  logic [31:0]                        mem_rdata_i,
    output logic                               i_we_o,
    output logic                               d_we_o,
    output logic [31-OFFSET:0]                 w_virtual_page_o,
    output logic [PHYS_ADDR_SIZE-OFFSET-1:0]   w_phys_page_o,
    output logic                               busy_o
);

    localparam int VW = 32 - OFFSET;
    localparam int PW = PHYS_ADDR_SIZE - OFFSET;

    pw_state_t       state_reg, state_next;
    logic            grant_valid, grant_d;
    logic            side_d_reg;
    logic [VW-1:0]   vpage_reg;
    logic [VW-1:0]   vpage_sel;
    logic [31:0]     addr_reg;
    logic [PW-1:0]   pte_page_reg;
    // Served side is ignored for the first idle cycle after its done/fault,
    // so a requester that lowers its miss one cycle late is not walked twice.
    logic [1:0]      served_mask_reg;
    logic            unused_rdata;

    assign unused_rdata = ^mem_rdata_i;
    assign vpage_sel    = grant_d ? d_vpage_i : i_vpage_i;

    pw_rr_arbiter u_arb (
        .clock       (clock),
        .reset       (reset),
        .en          (state_reg == ST_IDLE),
        .i_req       (i_miss_i & ~served_mask_reg[0]),
        .d_req       (d_miss_i & ~served_mask_reg[1]),
        .grant_valid (grant_valid),
        .grant_d     (grant_d)
    );

`ifdef PAGE_WALKER_TIMEOUT_EN
    logic [31:0] wait_cnt_reg;
    logic        timed_out;

    assign timed_out = (wait_cnt_reg == 32'(TIMEOUT - 1));

    always_ff @(posedge clock) begin
        if (reset) begin
            wait_cnt_reg <= '0;
        end else if (state_reg == ST_IDLE) begin
            wait_cnt_reg <= '0;
        end else if (state_reg == ST_REQ && !mem_ack_i) begin
            wait_cnt_reg <= wait_cnt_reg + 32'd1;
        end
    end
`else
    localparam int unused_timeout = TIMEOUT;
    logic          timed_out;
    assign timed_out = 1'b0;
`endif

    // State register
    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE:  if (grant_valid) state_next = ST_REQ;
            ST_REQ: begin
                if (mem_ack_i) begin
                    state_next = mem_rdata_i[PTE_VALID_BIT] ? ST_FILL : ST_FAULT;
                end else if (timed_out) begin
                    state_next = ST_FAULT;
                end
            end
            ST_FILL:  state_next = ST_RESP;
            ST_RESP:  state_next = ST_IDLE;
            ST_FAULT: state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
    end

    // Walk context: captured at grant (ptbr included) and at PTE ack
    always_ff @(posedge clock) begin
        if (reset) begin
            side_d_reg      <= 1'b0;
            vpage_reg       <= '0;
            addr_reg        <= '0;
            pte_page_reg    <= '0;
            served_mask_reg <= 2'b00;
        end else begin
            if (state_reg == ST_IDLE && grant_valid) begin
                side_d_reg <= grant_d;
                vpage_reg  <= vpage_sel;
                addr_reg   <= ptbr_i + {{(OFFSET-2){1'b0}}, vpage_sel, 2'b00};
            end
            if (state_reg == ST_REQ && mem_ack_i) begin
                pte_page_reg <= mem_rdata_i[PHYS_ADDR_SIZE-1:OFFSET];
            end
            if (state_reg == ST_RESP || state_reg == ST_FAULT) begin
                served_mask_reg <= side_d_reg ? 2'b10 : 2'b01;
            end else begin
                served_mask_reg <= 2'b00;
            end
        end
    end

    // Output logic; reset forces every output low in the reset cycle itself
    always_comb begin
        mem_req_o        = 1'b0;
        mem_addr_o       = '0;
        i_we_o           = 1'b0;
        d_we_o           = 1'b0;
        w_virtual_page_o = '0;
        w_phys_page_o    = '0;
        i_done_o         = 1'b0;
        d_done_o         = 1'b0;
        i_fault_o        = 1'b0;
        d_fault_o        = 1'b0;
        busy_o           = 1'b0;
        if (!reset) begin
            busy_o = (state_reg != ST_IDLE);
            case (state_reg)
                ST_REQ: begin
                    mem_req_o  = 1'b1;
                    mem_addr_o = addr_reg;
                end
                ST_FILL: begin
                    i_we_o           = ~side_d_reg;
                    d_we_o           = side_d_reg;
                    w_virtual_page_o = vpage_reg;
                    w_phys_page_o    = pte_page_reg;
                end
                ST_RESP: begin
                    i_done_o = ~side_d_reg;
                    d_done_o = side_d_reg;
                end
                ST_FAULT: begin
                    i_fault_o = ~side_d_reg;
                    d_fault_o = side_d_reg;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_page_walker.sv
// Directed testbench for page_walker (OFFSET=12, PHYS_ADDR_SIZE=24, TIMEOUT=4).
module tb_page_walker;

    logic        clock = 1'b0;
    logic        reset;
    logic        i_miss_i, d_miss_i;
    logic [19:0] i_vpage_i, d_vpage_i;
    logic        i_done_o, i_fault_o, d_done_o, d_fault_o;
    logic [31:0] ptbr_i;
    logic        mem_req_o;
    logic [31:0] mem_addr_o;
    logic        mem_ack_i;
    logic [31:0] mem_rdata_i;
    logic        i_we_o, d_we_o;
    logic [19:0] w_virtual_page_o;
    logic [11:0] w_phys_page_o;
    logic        busy_o;

    int checks   = 0;
    int failures = 0;

    always #5 clock = ~clock;

    page_walker #(.OFFSET(12), .PHYS_ADDR_SIZE(24), .TIMEOUT(4)) dut (
        .clock            (clock),
        .reset            (reset),
        .i_miss_i         (i_miss_i),
        .i_vpage_i        (i_vpage_i),
        .i_done_o         (i_done_o),
        .i_fault_o        (i_fault_o),
        .d_miss_i         (d_miss_i),
        .d_vpage_i        (d_vpage_i),
        .d_done_o         (d_done_o),
        .d_fault_o        (d_fault_o),
        .ptbr_i           (ptbr_i),
        .mem_req_o        (mem_req_o),
        .mem_addr_o       (mem_addr_o),
        .mem_ack_i        (mem_ack_i),
        .mem_rdata_i      (mem_rdata_i),
        .i_we_o           (i_we_o),
        .d_we_o           (d_we_o),
        .w_virtual_page_o (w_virtual_page_o),
        .w_phys_page_o    (w_phys_page_o),
        .busy_o           (busy_o)
    );

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic apply_reset();
        reset = 1'b1; i_miss_i = 1'b0; d_miss_i = 1'b0; mem_ack_i = 1'b0;
        step(); step();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        logic [10:0] outs;
        reset = 1'b1; i_miss_i = 1'b1; d_miss_i = 1'b1; mem_ack_i = 1'b1;
        i_vpage_i = 20'h1; d_vpage_i = 20'h2; ptbr_i = 32'h0; mem_rdata_i = 32'h1;
        #1;
        step(); step();
        outs = {mem_req_o, i_we_o, d_we_o, i_done_o, d_done_o, i_fault_o, d_fault_o,
                busy_o, |mem_addr_o, |w_virtual_page_o, |w_phys_page_o};
        checks++;
        if (outs !== 11'b0) begin
            failures++; $display("FAIL reset_outputs actual=%b required=0", outs);
        end
        i_miss_i = 1'b0; d_miss_i = 1'b0; mem_ack_i = 1'b0;
        reset = 1'b0;
        step();
        checks++;
        if (busy_o !== 1'b0 || mem_req_o !== 1'b0) begin
            failures++; $display("FAIL reset_idle actual busy=%b req=%b required 0/0", busy_o, mem_req_o);
        end
        $display("txn reset: outputs quiet");
    endtask

    task automatic test_basic();
        apply_reset();
        i_miss_i = 1'b1; i_vpage_i = 20'h00012; ptbr_i = 32'h1000;
        step();                                   // REQ, first cycle
        checks++;
        if (mem_req_o !== 1'b1 || mem_addr_o !== 32'h1048) begin
            failures++; $display("FAIL basic_req actual req=%b addr=%h required 1/00001048", mem_req_o, mem_addr_o);
        end
        ptbr_i = 32'hDEAD0000;                    // must not disturb the walk
        step();
        checks++;
        if (mem_req_o !== 1'b1 || mem_addr_o !== 32'h1048 || busy_o !== 1'b1) begin
            failures++; $display("FAIL basic_hold actual req=%b addr=%h busy=%b required 1/00001048/1", mem_req_o, mem_addr_o, busy_o);
        end
        step();
        mem_ack_i = 1'b1; mem_rdata_i = 32'h00ABC001;
        step();                                   // FILL
        mem_ack_i = 1'b0;
        checks++;
        if (mem_req_o !== 1'b0 || i_we_o !== 1'b1 || d_we_o !== 1'b0 ||
            w_virtual_page_o !== 20'h00012 || w_phys_page_o !== 12'hABC) begin
            failures++; $display("FAIL basic_fill actual req=%b iwe=%b dwe=%b vp=%h pp=%h required 0/1/0/00012/abc",
                                 mem_req_o, i_we_o, d_we_o, w_virtual_page_o, w_phys_page_o);
        end
        step();                                   // RESP
        checks++;
        if (i_done_o !== 1'b1 || i_we_o !== 1'b0 || w_phys_page_o !== 12'h0 || i_fault_o !== 1'b0) begin
            failures++; $display("FAIL basic_done actual done=%b we=%b pp=%h fault=%b required 1/0/000/0", i_done_o, i_we_o, w_phys_page_o, i_fault_o);
        end
        i_miss_i = 1'b0;
        step();                                   // IDLE
        step();
        checks++;
        if (busy_o !== 1'b0 || mem_req_o !== 1'b0 || i_done_o !== 1'b0) begin
            failures++; $display("FAIL basic_idle actual busy=%b req=%b done=%b required 0/0/0", busy_o, mem_req_o, i_done_o);
        end
        $display("txn basic: I vpage=00012 addr=00001048 phys=abc");
    endtask

    task automatic test_arbitration();
        int          exp_d [7]     = '{0, 1, 0, 1, 0, 1, 0};
        logic [1:0]  raise_tab [7] = '{2'b00, 2'b11, 2'b00, 2'b01, 2'b11, 2'b00, 2'b00};
        logic [31:0] exp_addr;
        apply_reset();
        ptbr_i = 32'h0; i_vpage_i = 20'h10; d_vpage_i = 20'h20;
        i_miss_i = 1'b1; d_miss_i = 1'b1;
        for (int k = 0; k < 7; k++) begin
            exp_addr = (exp_d[k] != 0) ? 32'h80 : 32'h40;
            step();                               // REQ
            checks++;
            if (mem_req_o !== 1'b1 || mem_addr_o !== exp_addr) begin
                failures++; $display("FAIL arb_addr walk=%0d actual req=%b addr=%h required 1/%h", k, mem_req_o, mem_addr_o, exp_addr);
            end
            mem_ack_i = 1'b1;
            mem_rdata_i = (exp_d[k] != 0) ? 32'h00222001 : 32'h00111001;
            step();                               // FILL
            mem_ack_i = 1'b0;
            checks++;
            if ({i_we_o, d_we_o} !== ((exp_d[k] != 0) ? 2'b01 : 2'b10)) begin
                failures++; $display("FAIL arb_we walk=%0d actual iwe=%b dwe=%b", k, i_we_o, d_we_o);
            end
            step();                               // RESP
            checks++;
            if ({i_done_o, d_done_o} !== ((exp_d[k] != 0) ? 2'b01 : 2'b10)) begin
                failures++; $display("FAIL arb_done walk=%0d actual idone=%b ddone=%b", k, i_done_o, d_done_o);
            end
            $display("txn arb walk=%0d side=%s addr=%h", k, (exp_d[k] != 0) ? "D" : "I", mem_addr_o);
            if (exp_d[k] != 0) d_miss_i = 1'b0; else i_miss_i = 1'b0;
            step();                               // IDLE
            if (raise_tab[k] != 2'b00) begin
                checks++;
                if (busy_o !== 1'b0) begin
                    failures++; $display("FAIL arb_rewalk walk=%0d actual busy=%b required 0", k, busy_o);
                end
                step();
                if (raise_tab[k][0]) i_miss_i = 1'b1;
                if (raise_tab[k][1]) d_miss_i = 1'b1;
            end
        end
    endtask

    task automatic test_fault();
        apply_reset();
        d_miss_i = 1'b1; d_vpage_i = 20'h5; ptbr_i = 32'h2000;
        step();
        checks++;
        if (mem_addr_o !== 32'h2014) begin
            failures++; $display("FAIL fault_addr actual=%h required=00002014", mem_addr_o);
        end
        mem_ack_i = 1'b1; mem_rdata_i = 32'h00ABC000;
        step();                                   // FAULT
        mem_ack_i = 1'b0;
        checks++;
        if (d_fault_o !== 1'b1 || i_fault_o !== 1'b0 || i_we_o !== 1'b0 || d_we_o !== 1'b0 ||
            d_done_o !== 1'b0 || mem_req_o !== 1'b0) begin
            failures++; $display("FAIL fault_pulse actual dfault=%b ifault=%b we=%b%b done=%b req=%b required 1/0/00/0/0",
                                 d_fault_o, i_fault_o, i_we_o, d_we_o, d_done_o, mem_req_o);
        end
        d_miss_i = 1'b0;
        step();
        checks++;
        if (d_fault_o !== 1'b0 || busy_o !== 1'b0 || d_we_o !== 1'b0) begin
            failures++; $display("FAIL fault_after actual fault=%b busy=%b we=%b required 0/0/0", d_fault_o, busy_o, d_we_o);
        end
        $display("txn fault: D vpage=00005 rdata=00abc000");
    endtask

    task automatic test_reset_midwalk();
        apply_reset();
        i_miss_i = 1'b1; i_vpage_i = 20'h3; ptbr_i = 32'h100;
        step();                                   // REQ
        checks++;
        if (mem_req_o !== 1'b1) begin
            failures++; $display("FAIL mid_req actual=%b required=1", mem_req_o);
        end
        step();
        reset = 1'b1;
        #1;
        checks++;
        if (mem_req_o !== 1'b0 || busy_o !== 1'b0) begin
            failures++; $display("FAIL mid_reset_cycle actual req=%b busy=%b required 0/0", mem_req_o, busy_o);
        end
        step();
        reset = 1'b0; mem_ack_i = 1'b1; mem_rdata_i = 32'h00FFF001;
        #1;
        checks++;
        if ({mem_req_o, i_we_o, i_done_o, i_fault_o} !== 4'b0) begin
            failures++; $display("FAIL mid_after actual req/we/done/fault=%b required 0000",
                                 {mem_req_o, i_we_o, i_done_o, i_fault_o});
        end
        step();                                   // pending miss re-walked
        mem_ack_i = 1'b0;
        checks++;
        if (mem_req_o !== 1'b1 || mem_addr_o !== 32'h10C || i_we_o !== 1'b0) begin
            failures++; $display("FAIL mid_rewalk actual req=%b addr=%h we=%b required 1/0000010c/0", mem_req_o, mem_addr_o, i_we_o);
        end
        mem_ack_i = 1'b1; mem_rdata_i = 32'h00777001;
        step();
        mem_ack_i = 1'b0;
        checks++;
        if (i_we_o !== 1'b1 || w_phys_page_o !== 12'h777) begin
            failures++; $display("FAIL mid_fill actual we=%b pp=%h required 1/777", i_we_o, w_phys_page_o);
        end
        step();
        i_miss_i = 1'b0;
        step();
        $display("txn reset_midwalk: walk abandoned, miss re-walked");
    endtask

    task automatic test_wrap();
        apply_reset();
        i_miss_i = 1'b1; i_vpage_i = 20'h1; ptbr_i = 32'hFFFFFFFC;
        step();
        checks++;
        if (mem_req_o !== 1'b1 || mem_addr_o !== 32'h0) begin
            failures++; $display("FAIL wrap_addr actual req=%b addr=%h required 1/00000000", mem_req_o, mem_addr_o);
        end
        mem_ack_i = 1'b1; mem_rdata_i = 32'h00123001;
        step();
        mem_ack_i = 1'b0;
        step();
        checks++;
        if (i_done_o !== 1'b1) begin
            failures++; $display("FAIL wrap_done actual=%b required=1", i_done_o);
        end
        i_miss_i = 1'b0;
        step();
        $display("txn wrap: ptbr=fffffffc vpage=00001 addr=00000000");
    endtask

`ifdef PAGE_WALKER_TIMEOUT_EN
    task automatic test_timeout();
        apply_reset();
        i_miss_i = 1'b1; i_vpage_i = 20'h7; ptbr_i = 32'h0;
        for (int c = 1; c <= 4; c++) begin
            step();
            checks++;
            if (mem_req_o !== 1'b1) begin
                failures++; $display("FAIL tmo_req cycle=%0d actual=%b required=1", c, mem_req_o);
            end
        end
        step();                                   // cycle 5: FAULT
        checks++;
        if (i_fault_o !== 1'b1 || mem_req_o !== 1'b0) begin
            failures++; $display("FAIL tmo_fault actual fault=%b req=%b required 1/0", i_fault_o, mem_req_o);
        end
        i_miss_i = 1'b0; mem_ack_i = 1'b1; mem_rdata_i = 32'h00555001;
        step();
        mem_ack_i = 1'b0;
        step();
        checks++;
        if (i_we_o !== 1'b0 || i_done_o !== 1'b0 || busy_o !== 1'b0) begin
            failures++; $display("FAIL tmo_late_ack actual we=%b done=%b busy=%b required 0/0/0", i_we_o, i_done_o, busy_o);
        end
        $display("txn timeout: fault after 4 request cycles");
    endtask
`else
    task automatic test_long_wait();
        apply_reset();
        i_miss_i = 1'b1; i_vpage_i = 20'h9; ptbr_i = 32'h0;
        step();
        repeat (300) step();
        checks++;
        if (mem_req_o !== 1'b1 || mem_addr_o !== 32'h24 || i_fault_o !== 1'b0) begin
            failures++; $display("FAIL long_wait actual req=%b addr=%h fault=%b required 1/00000024/0", mem_req_o, mem_addr_o, i_fault_o);
        end
        mem_ack_i = 1'b1; mem_rdata_i = 32'h00001001;
        step();
        mem_ack_i = 1'b0;
        checks++;
        if (i_we_o !== 1'b1 || w_phys_page_o !== 12'h001) begin
            failures++; $display("FAIL long_fill actual we=%b pp=%h required 1/001", i_we_o, w_phys_page_o);
        end
        step();
        i_miss_i = 1'b0;
        step();
        $display("txn long_wait: request held 301 cycles");
    endtask
`endif

    initial begin
        reset = 1'b1; i_miss_i = 1'b0; d_miss_i = 1'b0; mem_ack_i = 1'b0;
        i_vpage_i = '0; d_vpage_i = '0; ptbr_i = '0; mem_rdata_i = '0;
        test_reset();
        test_basic();
        test_arbitration();
        test_fault();
        test_reset_midwalk();
        test_wrap();
`ifdef PAGE_WALKER_TIMEOUT_EN
        test_timeout();
`else
        test_long_wait();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
